// File: rtl/legv8_instr_encoder.sv
// LEGv8 instruction encoder: turns op/register/immediate descriptors into 32-bit
// machine words queued in a small FIFO with sequential byte addresses.
// Optional macro ENC_RANGE_CHECK_EN rejects D-type descriptors whose immediate exceeds 9 bits.
module legv8_instr_encoder #(
   parameter int                DEPTH     = 4,
   parameter int                ADDR_W    = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_op,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rn,
   input  logic [4:0]        in_rm,
   input  logic [18:0]       in_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   localparam logic [2:0] OP_LDUR = 3'd0;
   localparam logic [2:0] OP_STUR = 3'd1;
   localparam logic [2:0] OP_CBZ  = 3'd2;
   localparam logic [2:0] OP_ADD  = 3'd3;
   localparam logic [2:0] OP_SUB  = 3'd4;
   localparam logic [2:0] OP_AND  = 3'd5;
   localparam logic [2:0] OP_ORR  = 3'd6;

   function automatic logic [31:0] encode(input logic [2:0]  op,
                                          input logic [4:0]  rt,
                                          input logic [4:0]  rn,
                                          input logic [4:0]  rm,
                                          input logic [18:0] imm);
      logic [31:0] w;
      w = 32'd0;
      case (op)
         OP_LDUR: w = {11'b11111000010, imm[8:0], 2'b00, rn, rt};
         OP_STUR: w = {11'b11111000000, imm[8:0], 2'b00, rn, rt};
         OP_CBZ:  w = {8'b10110100, imm, rt};
         OP_ADD:  w = {11'b10001011000, rm, 6'd0, rn, rt};
         OP_SUB:  w = {11'b11001011000, rm, 6'd0, rn, rt};
         OP_AND:  w = {11'b10001010000, rm, 6'd0, rn, rt};
         OP_ORR:  w = {11'b10101010000, rm, 6'd0, rn, rt};
         default: w = 32'd0;
      endcase
      return w;
   endfunction

   logic [31:0]       mem_instr [DEPTH];
   logic [ADDR_W-1:0] mem_addr  [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_nxt;
   logic [CNT_W-1:0]  count, remain, count_nxt;
   logic [ADDR_W-1:0] addr_cnt;
   logic              up;
   logic              full, accept, pop, push, illegal;
   logic [31:0]       enc_word_p0;
   logic [31:0]       head_instr_nxt;
   logic [ADDR_W-1:0] head_addr_nxt;

   assign full        = (count == CNT_W'(DEPTH));
   assign in_ready    = up && !full;
   assign out_valid   = (count != '0);
   assign accept      = in_valid && in_ready;
   assign pop         = out_valid && out_ready;
   assign enc_word_p0 = encode(in_op, in_rt, in_rn, in_rm, in_imm);

   always_comb begin
      illegal = (in_op == 3'd7);
`ifdef ENC_RANGE_CHECK_EN
      if ((in_op == OP_LDUR || in_op == OP_STUR) && (in_imm[18:9] != '0))
         illegal = 1'b1;
`endif
   end

   assign push = accept && !illegal && !clear;

   // Head of queue after this cycle's pop/push; a push into an empty
   // queue bypasses the storage array so the word is visible next cycle.
   always_comb begin
      rd_nxt         = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
      remain         = count - CNT_W'(pop);
      count_nxt      = remain + CNT_W'(push);
      head_instr_nxt = mem_instr[rd_nxt];
      head_addr_nxt  = mem_addr[rd_nxt];
      if (remain == '0) begin
         head_instr_nxt = enc_word_p0;
         head_addr_nxt  = addr_cnt;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_instr[wr_ptr] <= enc_word_p0;
         mem_addr[wr_ptr]  <= addr_cnt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         up        <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         addr_cnt  <= BASE_ADDR;
         err       <= 1'b0;
         out_instr <= 32'd0;
         out_addr  <= '0;
      end else begin
         up <= 1'b1;
         if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            addr_cnt <= BASE_ADDR;
            err      <= 1'b0;
         end else begin
            if (push) begin
               wr_ptr   <= wr_ptr + PTR_W'(1);
               addr_cnt <= addr_cnt + ADDR_W'(4);
            end
            if (pop)
               rd_ptr <= rd_nxt;
            count <= count_nxt;
            if (accept && illegal)
               err <= 1'b1;
            // Output registers hold their last word once the queue drains.
            if (count_nxt != '0) begin
               out_instr <= head_instr_nxt;
               out_addr  <= head_addr_nxt;
            end
         end
      end
   end

endmodule

// File: tb/tb_legv8_instr_encoder.sv
// Scoreboard bench for legv8_instr_encoder: drivers queue expected words, monitors
// pop and compare whenever a DUT hands a word to its consumer.
module tb_legv8_instr_encoder;

   typedef struct {
      logic [31:0] instr;
      logic [7:0]  addr;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset, clear;
   logic        in_valid, in_ready, out_valid, out_ready, err;
   logic [2:0]  in_op;
   logic [4:0]  in_rt, in_rn, in_rm;
   logic [18:0] in_imm;
   logic [31:0] out_instr;
   logic [7:0]  out_addr;

   logic        w_in_valid, w_in_ready, w_out_valid, w_err;
   logic [31:0] w_out_instr;
   logic [3:0]  w_out_addr;

   exp_t q[$];
   exp_t wq[$];
   exp_t mon_e, wmon_e;
   int   errors = 0;
   int   checks = 0;
   logic [7:0] exp_addr;

   always #5 clk = ~clk;

   legv8_instr_encoder #(.DEPTH(4), .ADDR_W(8), .BASE_ADDR(8'h00)) u_dut (
      .clk(clk), .reset(reset), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_rt(in_rt), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_addr(out_addr), .err(err));

   legv8_instr_encoder #(.DEPTH(4), .ADDR_W(4), .BASE_ADDR(4'h0)) u_wrap (
      .clk(clk), .reset(reset), .clear(clear),
      .in_valid(w_in_valid), .in_ready(w_in_ready),
      .in_op(in_op), .in_rt(in_rt), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
      .out_valid(w_out_valid), .out_ready(1'b1),
      .out_instr(w_out_instr), .out_addr(w_out_addr), .err(w_err));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (reset && out_valid && out_ready) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %h at %h required none", out_instr, out_addr);
         end else begin
            mon_e = q.pop_front();
            check("instr", out_instr, mon_e.instr);
            check("addr", {24'd0, out_addr}, {24'd0, mon_e.addr});
         end
      end
   end

   always @(negedge clk) begin
      if (reset && w_out_valid) begin
         if (wq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wrap_unexpected: got %h required none", w_out_instr);
         end else begin
            wmon_e = wq.pop_front();
            check("wrap_instr", w_out_instr, wmon_e.instr);
            check("wrap_addr", {28'd0, w_out_addr}, {24'd0, wmon_e.addr});
         end
      end
   end

   // Starts and ends just after a rising edge. sel=1 targets the ADDR_W=4 instance,
   // whose expected address is given explicitly in waddr.
   task automatic send(input bit sel, input logic [2:0] op, input logic [4:0] rt,
                       input logic [4:0] rn, input logic [4:0] rm, input logic [18:0] imm,
                       input logic [31:0] word, input bit legal, input logic [7:0] waddr);
      int n;
      exp_t e;
      in_op = op; in_rt = rt; in_rn = rn; in_rm = rm; in_imm = imm;
      if (sel) w_in_valid = 1'b1; else in_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if ((sel ? w_in_ready : in_ready) === 1'b1) break;
         n++;
         if (n > 50) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 required 1");
            break;
         end
      end
      if (legal && n <= 50) begin
         e.instr = word;
         if (sel) begin
            e.addr = waddr;
            wq.push_back(e);
         end else begin
            e.addr = exp_addr;
            q.push_back(e);
            exp_addr = exp_addr + 8'd4;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      w_in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 || wq.size() != 0) begin
         @(negedge clk);
         n++;
         if (n > 100) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d words pending required 0", q.size() + wq.size());
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      exp_addr = 8'h00;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish required finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0; clear = 1'b0; in_valid = 1'b0; w_in_valid = 1'b0; out_ready = 1'b1;
      in_op = 3'd0; in_rt = 5'd0; in_rn = 5'd0; in_rm = 5'd0; in_imm = 19'd0;
      exp_addr = 8'h00;

      #12;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_instr", out_instr, 32'd0);
      check("rst_out_addr", {24'd0, out_addr}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Encodings, free-flowing consumer
      send(0, 3'd3, 5'd3, 5'd1, 5'd2, 19'd0, 32'h8B020023, 1, 8'h00);
      send(0, 3'd4, 5'd3, 5'd1, 5'd2, 19'd0, 32'hCB020023, 1, 8'h00);
      send(0, 3'd5, 5'd3, 5'd1, 5'd2, 19'd0, 32'h8A020023, 1, 8'h00);
      send(0, 3'd6, 5'd3, 5'd1, 5'd2, 19'd0, 32'hAA020023, 1, 8'h00);
      send(0, 3'd0, 5'd9, 5'd22, 5'd0, 19'd64, 32'hF84402C9, 1, 8'h00);
      send(0, 3'd1, 5'd9, 5'd22, 5'd0, 19'd64, 32'hF80402C9, 1, 8'h00);
      send(0, 3'd2, 5'd5, 5'd0, 5'd0, 19'd3, 32'hB4000065, 1, 8'h00);
      drain();
      check("drained_out_valid", {31'd0, out_valid}, 32'd0);
      check("hold_out_instr", out_instr, 32'hB4000065);

      // Backpressure: four fill the FIFO, fifth waits
      do_clear();
      out_ready = 1'b0;
      send(0, 3'd3, 5'd3, 5'd1, 5'd2, 19'd0, 32'h8B020023, 1, 8'h00);
      send(0, 3'd4, 5'd3, 5'd1, 5'd2, 19'd0, 32'hCB020023, 1, 8'h00);
      send(0, 3'd5, 5'd3, 5'd1, 5'd2, 19'd0, 32'h8A020023, 1, 8'h00);
      send(0, 3'd6, 5'd3, 5'd1, 5'd2, 19'd0, 32'hAA020023, 1, 8'h00);
      check("full_in_ready", {31'd0, in_ready}, 32'd0);
      fork
         send(0, 3'd3, 5'd31, 5'd31, 5'd31, 19'd0, 32'h8B1F03FF, 1, 8'h00);
         begin
            repeat (3) @(negedge clk);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_out_valid", {31'd0, out_valid}, 32'd1);
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // Illegal op between two legal words
      do_clear();
      send(0, 3'd3, 5'd3, 5'd1, 5'd2, 19'd0, 32'h8B020023, 1, 8'h00);
      send(0, 3'd7, 5'd3, 5'd1, 5'd2, 19'd0, 32'h00000000, 0, 8'h00);
      check("illegal_err", {31'd0, err}, 32'd1);
      send(0, 3'd3, 5'd31, 5'd31, 5'd31, 19'd0, 32'h8B1F03FF, 1, 8'h00);
      drain();
      check("err_sticky", {31'd0, err}, 32'd1);
      do_clear();
      check("clear_err", {31'd0, err}, 32'd0);
      send(0, 3'd6, 5'd3, 5'd1, 5'd2, 19'd0, 32'hAA020023, 1, 8'h00);
      drain();

      // Address wrap on the 4-bit instance
      send(1, 3'd3, 5'd3, 5'd1, 5'd2, 19'd0, 32'h8B020023, 1, 8'h00);
      send(1, 3'd4, 5'd3, 5'd1, 5'd2, 19'd0, 32'hCB020023, 1, 8'h04);
      send(1, 3'd5, 5'd3, 5'd1, 5'd2, 19'd0, 32'h8A020023, 1, 8'h08);
      send(1, 3'd6, 5'd3, 5'd1, 5'd2, 19'd0, 32'hAA020023, 1, 8'h0C);
      send(1, 3'd2, 5'd5, 5'd0, 5'd0, 19'd3, 32'hB4000065, 1, 8'h00);
      drain();

      // Asynchronous reset with words in flight
      do_clear();
      out_ready = 1'b0;
      send(0, 3'd3, 5'd3, 5'd1, 5'd2, 19'd0, 32'h8B020023, 1, 8'h00);
      send(0, 3'd4, 5'd3, 5'd1, 5'd2, 19'd0, 32'hCB020023, 1, 8'h00);
      send(0, 3'd5, 5'd3, 5'd1, 5'd2, 19'd0, 32'h8A020023, 1, 8'h00);
      #2;
      reset = 1'b0;
      #1;
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
      q.delete();
      wq.delete();
      exp_addr = 8'h00;
      @(negedge clk);
      reset = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      send(0, 3'd3, 5'd31, 5'd31, 5'd31, 19'd0, 32'h8B1F03FF, 1, 8'h00);
      drain();

      // Out-of-range D-type immediate
      do_clear();
`ifdef ENC_RANGE_CHECK_EN
      send(0, 3'd0, 5'd9, 5'd22, 5'd0, 19'h200, 32'h00000000, 0, 8'h00);
      check("range_err", {31'd0, err}, 32'd1);
`else
      send(0, 3'd0, 5'd9, 5'd22, 5'd0, 19'h200, 32'hF84002C9, 1, 8'h00);
      check("range_err", {31'd0, err}, 32'd0);
`endif
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
